// File: rtl/sys_cfg_regbank.sv
`timescale 1ns/1ps
// sys_cfg_regbank: BRAM-style register bank with control, status, pulse and
// optional interrupt words. Word map: CTRL[0..REG_NUM-1], STATUS after that,
// then PULSE, IRQ_STAT, IRQ_EN. Define SYS_CFG_IRQ_EN to build the interrupt
// block; without it the IRQ words read 0 and irq is tied low.
module sys_cfg_regbank #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_NUM   = DATA_WIDTH / 8,
  parameter int REG_NUM    = 8,
  parameter int STAT_NUM   = 4
) (
  input  logic                                                 clk,
  input  logic                                                 rstn,
  input  logic                                                 bram_en,
  input  logic [BYTE_NUM-1:0]                                  bram_we,
  input  logic [ADDR_WIDTH-1:0]                                bram_addr,
  input  logic [DATA_WIDTH-1:0]                                bram_din,
  output logic [DATA_WIDTH-1:0]                                bram_dout,
  output logic [REG_NUM*DATA_WIDTH-1:0]                        ctrl_reg,
  input  logic [((STAT_NUM > 0) ? STAT_NUM : 1)*DATA_WIDTH-1:0] status_in,
  output logic [DATA_WIDTH-1:0]                                pulse_out,
  input  logic [DATA_WIDTH-1:0]                                irq_evt,
  output logic                                                 irq
);

  localparam int          LSB        = $clog2(BYTE_NUM);
  localparam logic [31:0] PULSE_IDX  = 32'(REG_NUM + STAT_NUM);
  localparam logic [31:0] ISTAT_IDX  = 32'(REG_NUM + STAT_NUM + 1);
  localparam logic [31:0] IEN_IDX    = 32'(REG_NUM + STAT_NUM + 2);

  logic [31:0]                   widx;
  logic                          wr_en;
  logic                          rd_en;
  logic [DATA_WIDTH-1:0]         wmask;
  logic [DATA_WIDTH-1:0]         wdata_m;
  logic [DATA_WIDTH-1:0]         rd_data;

  logic [REG_NUM*DATA_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0]         dout_q, dout_d;
  logic [DATA_WIDTH-1:0]         pulse_q, pulse_d;

`ifdef SYS_CFG_IRQ_EN
  logic [DATA_WIDTH-1:0]         irq_stat_q, irq_stat_d;
  logic [DATA_WIDTH-1:0]         irq_en_q, irq_en_d;
  logic                          irq_q, irq_d;
`endif

  // Byte offset bits never take part in decode.
  assign widx  = 32'(bram_addr >> LSB);
  assign wr_en = bram_en & (|bram_we);
  assign rd_en = bram_en & ~(|bram_we);

  // Expand per-byte write enables into a bit mask and pre-mask write data.
  always_comb begin
    wmask = '0;
    for (int b = 0; b < BYTE_NUM; b++) begin
      wmask[b*8 +: 8] = {8{bram_we[b]}};
    end
    wdata_m = bram_din & wmask;
  end

  // Control register byte-lane writes.
  always_comb begin
    ctrl_d = ctrl_q;
    for (int k = 0; k < REG_NUM; k++) begin
      if (wr_en && (widx == 32'(k))) begin
        ctrl_d[k*DATA_WIDTH +: DATA_WIDTH] =
          (ctrl_q[k*DATA_WIDTH +: DATA_WIDTH] & ~wmask) | wdata_m;
      end
    end
  end

  // Read mux; PULSE and unmapped words fall through to zero.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < REG_NUM; k++) begin
      if (widx == 32'(k)) rd_data = ctrl_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int s = 0; s < STAT_NUM; s++) begin
      if (widx == 32'(REG_NUM + s)) rd_data = status_in[s*DATA_WIDTH +: DATA_WIDTH];
    end
`ifdef SYS_CFG_IRQ_EN
    if (widx == ISTAT_IDX) rd_data = irq_stat_q;
    if (widx == IEN_IDX)   rd_data = irq_en_q;
`endif
  end

  // Read data is held across non-read cycles; pulses last a single cycle.
  always_comb begin
    dout_d  = rd_en ? rd_data : dout_q;
    pulse_d = (wr_en && (widx == PULSE_IDX)) ? wdata_m : '0;
  end

  // Core register state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_q  <= '0;
      dout_q  <= '0;
      pulse_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      dout_q  <= dout_d;
      pulse_q <= pulse_d;
    end
  end

  assign ctrl_reg  = ctrl_q;
  assign bram_dout = dout_q;
  assign pulse_out = pulse_q;

`ifdef SYS_CFG_IRQ_EN
  // Sticky status with W1C; a new event in the clearing cycle keeps the bit.
  always_comb begin
    irq_stat_d = irq_stat_q;
    irq_en_d   = irq_en_q;
    if (wr_en && (widx == ISTAT_IDX)) irq_stat_d = irq_stat_q & ~wdata_m;
    irq_stat_d = irq_stat_d | irq_evt;
    if (wr_en && (widx == IEN_IDX)) irq_en_d = (irq_en_q & ~wmask) | wdata_m;
    irq_d = |(irq_stat_q & irq_en_q);
  end

  // Interrupt state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_stat_q <= '0;
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_stat_q <= irq_stat_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  logic unused_irq_evt;
  assign unused_irq_evt = |{1'b0, irq_evt, ISTAT_IDX, IEN_IDX};
  assign irq = 1'b0;
`endif

endmodule
